// File: rtl/puf_response_collector.sv
// puf_response_collector: settle, majority-vote and pack MKG PUF bits into handshaked response words
module puf_response_collector #(
  parameter int SETTLE_CYC = 4,
  parameter int VOTES      = 5,
  parameter int WORD_NIB   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           c_bits_in,
  input  logic [3:0]            mkg_in,
  output logic [4*WORD_NIB-1:0] resp_data,
  output logic [WORD_NIB-1:0]   resp_unstable,
  output logic [31:0]           resp_chal,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  busy
);
  localparam int NW = WORD_NIB > 1 ? $clog2(WORD_NIB) : 1;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT_NEW, OUT} state_t;
  state_t state, state_n;
  logic [31:0] chal_q;
  logic [7:0] settle_cnt;
  logic [3:0] samp_cnt;
  logic [3:0][3:0] ones, ones_n;
  logic [3:0] vote;
  logic unstable_n;
  logic [NW-1:0] nib_idx;
  logic chg, settle_done, samp_last, nib_last;
  assign chg = c_bits_in != chal_q;
  assign settle_done = settle_cnt == 8'(SETTLE_CYC - 1);
  assign samp_last = samp_cnt == 4'(VOTES - 1);
  assign nib_last = nib_idx == NW'(WORD_NIB - 1);
  assign busy = state != IDLE;
  // running counts including the current sample, and the vote they imply
  always_comb begin
    ones_n = '0;
    vote = '0;
    unstable_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ones_n[i] = ones[i] + {3'b0, mkg_in[i]};
      vote[i] = ones_n[i] >= 4'(VOTES / 2 + 1);
      unstable_n = unstable_n | (ones_n[i] != 4'd0 && ones_n[i] != 4'(VOTES));
    end
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: enable drop aborts collection, challenge change restarts settling
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = enable ? SETTLE : IDLE;
      SETTLE:   state_n = !enable ? IDLE : (!chg && settle_done) ? SAMPLE : SETTLE;
      SAMPLE:   state_n = !enable ? IDLE : chg ? SETTLE : !samp_last ? SAMPLE : nib_last ? OUT : WAIT_NEW;
      WAIT_NEW: state_n = !enable ? IDLE : chg ? SETTLE : WAIT_NEW;
      OUT:      state_n = !resp_ready ? OUT : enable ? WAIT_NEW : IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // datapath: challenge capture, counters, vote accumulation and word packing
  always_ff @(posedge clk) begin
    if (rst) begin
      chal_q <= '0;
      settle_cnt <= '0;
      samp_cnt <= '0;
      ones <= '0;
      nib_idx <= '0;
      resp_data <= '0;
      resp_unstable <= '0;
      resp_chal <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (enable) begin
            chal_q <= c_bits_in;
            settle_cnt <= '0;
            nib_idx <= '0;
          end
        SETTLE, SAMPLE, WAIT_NEW:
          if (enable) begin
            if (chg) begin
              chal_q <= c_bits_in;
              settle_cnt <= '0;
            end else if (state == SETTLE) begin
              settle_cnt <= settle_cnt + 8'd1;
              if (settle_done) begin
                ones <= '0;
                samp_cnt <= '0;
              end
            end else if (state == SAMPLE) begin
              ones <= ones_n;
              samp_cnt <= samp_cnt + 4'd1;
              if (samp_last) begin
                resp_data[4*nib_idx +: 4] <= vote;
                resp_unstable[nib_idx] <= unstable_n;
                if (nib_idx == '0) resp_chal <= chal_q;
                if (nib_last) resp_valid <= 1'b1;
                else nib_idx <= nib_idx + 1'b1;
              end
            end
          end
        OUT:
          if (resp_ready) begin
            resp_valid <= 1'b0;
            nib_idx <= '0;
            resp_unstable <= '0;
          end
        default: ;
      endcase
    end
  end
endmodule
